// File: rtl/arb8_ctrl.sv
// arb8_ctrl: 8-requester arbiter sharing one downstream resource.
// Fixed-priority (REQ[7] highest) or round-robin selection, grant held while
// the owner keeps requesting, forced release after MAX_HOLD cycles.
// Ports:
//   CLK      rising-edge clock
//   RST_N    asynchronous active-low reset
//   REQ      request vector, one bit per requester
//   MODE     0 = fixed priority, 1 = round-robin (sampled only in IDLE)
//   GNT      one-hot grant, zero when idle
//   GNT_ID   index of granted requester, 4'b1111 when no grant
//   GNT_VLD  high while a grant is held
//   TIMEOUT  one-cycle pulse when a grant is forcibly revoked
module arb8_ctrl #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] REQ,
    input  logic       MODE,
    output logic [7:0] GNT,
    output logic [3:0] GNT_ID,
    output logic       GNT_VLD,
    output logic       TIMEOUT
);

    localparam int unsigned NREQ  = 8;
    localparam int unsigned IDX_W = 3;
    localparam logic [3:0]  NO_ID = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   hold_cnt, hold_cnt_n;
    logic [IDX_W-1:0]   last, last_n;
    logic [7:0]         gnt_n;
    logic [3:0]         gnt_id_n;
    logic               gnt_vld_n;
    logic               timeout_n;
    logic [IDX_W-1:0]   win;

    // Winner selection. Loops run from lowest to highest priority so the
    // last assignment that hits is the winner.
    always_comb begin
        win = '0;
        if (!MODE) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (REQ[i]) win = IDX_W'(i);
            end
        end else begin
            // Search order last-1, last-2, ..., last; k=8 wraps to last itself.
            for (int k = int'(NREQ); k >= 1; k--) begin
                if (REQ[last - IDX_W'(k)]) win = last - IDX_W'(k);
            end
        end
    end

    // Next-state and registered-output values.
    always_comb begin
        state_n    = state;
        hold_cnt_n = hold_cnt;
        last_n     = last;
        gnt_n      = GNT;
        gnt_id_n   = GNT_ID;
        gnt_vld_n  = GNT_VLD;
        timeout_n  = 1'b0;

        case (state)
            S_IDLE: begin
                if (|REQ) begin
                    state_n    = S_GRANT;
                    gnt_n      = 8'h01 << win;
                    gnt_id_n   = {1'b0, win};
                    gnt_vld_n  = 1'b1;
                    hold_cnt_n = '0;
                end
            end
            S_GRANT: begin
                if (!REQ[GNT_ID[IDX_W-1:0]] || (hold_cnt == CNT_W'(MAX_HOLD - 1))) begin
                    state_n   = S_RELEASE;
                    timeout_n = REQ[GNT_ID[IDX_W-1:0]];
                    gnt_n     = '0;
                    gnt_id_n  = NO_ID;
                    gnt_vld_n = 1'b0;
                    last_n    = GNT_ID[IDX_W-1:0];
                end else begin
                    hold_cnt_n = hold_cnt + CNT_W'(1);
                end
            end
            S_RELEASE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n   = S_IDLE;
                gnt_n     = '0;
                gnt_id_n  = NO_ID;
                gnt_vld_n = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
            last     <= '0;
            GNT      <= '0;
            GNT_ID   <= NO_ID;
            GNT_VLD  <= 1'b0;
            TIMEOUT  <= 1'b0;
        end else begin
            state    <= state_n;
            hold_cnt <= hold_cnt_n;
            last     <= last_n;
            GNT      <= gnt_n;
            GNT_ID   <= gnt_id_n;
            GNT_VLD  <= gnt_vld_n;
            TIMEOUT  <= timeout_n;
        end
    end

endmodule

// File: tb/tb_arb8_ctrl.sv
// Self-checking bench for arb8_ctrl: table vectors, directed corner cases and
// randomized traffic against a behavioural model of the arbitration rules.
module tb_arb8_ctrl;

    localparam int unsigned MAX_HOLD = 16;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [7:0] REQ;
    logic       MODE;
    logic [7:0] GNT;
    logic [3:0] GNT_ID;
    logic       GNT_VLD;
    logic       TIMEOUT;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: who owns the resource, for how many cycles so far,
    // whether the handover dead time is pending, and the last owner.
    int m_owner;
    int m_held;
    bit m_cool;
    int m_last;
    bit m_to;

    always #5 CLK = ~CLK;

    arb8_ctrl #(.MAX_HOLD(MAX_HOLD), .CNT_W(5)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .REQ     (REQ),
        .MODE    (MODE),
        .GNT     (GNT),
        .GNT_ID  (GNT_ID),
        .GNT_VLD (GNT_VLD),
        .TIMEOUT (TIMEOUT)
    );

    typedef struct {
        logic [7:0] req;
        logic       mode;
        logic [7:0] gnt;
        logic [3:0] id;
        logic       to;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [7:0] r, input logic m, input int last);
        if (!m) begin
            for (int i = 7; i >= 0; i--) if (r[i]) return i;
        end else begin
            for (int k = 1; k <= 8; k++) begin
                int idx;
                idx = (last + 8 - k) % 8;
                if (r[idx]) return idx;
            end
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_cool  = 1'b0;
        m_last  = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] r, input logic m);
        m_to = 1'b0;
        if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
                m_cool  = 1'b1;
            end else if (m_held == int'(MAX_HOLD)) begin
                m_last  = m_owner;
                m_owner = -1;
                m_cool  = 1'b1;
                m_to    = 1'b1;
            end else begin
                m_held++;
            end
        end else if (m_cool) begin
            m_cool = 1'b0;
        end else if (r != 8'h00) begin
            m_owner = pick(r, m, m_last);
            m_held  = 1;
        end
    endtask

    task automatic check_outputs();
        logic [7:0] eg;
        logic [3:0] eid;
        eg  = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
        eid = (m_owner >= 0) ? 4'(m_owner) : 4'hF;
        chk("gnt",        32'(GNT),     32'(eg));
        chk("gnt_id",     32'(GNT_ID),  32'(eid));
        chk("gnt_vld",    32'(GNT_VLD), 32'(m_owner >= 0));
        chk("timeout",    32'(TIMEOUT), 32'(m_to));
        chk("inv_onehot", 32'($onehot0(GNT)), 32'(1));
        chk("inv_vld",    32'(GNT_VLD), 32'(|GNT));
        chk("inv_id",     32'((GNT_ID == 4'hF) == (GNT == 8'h00)), 32'(1));
    endtask

    // One clock: advance the model with the inputs seen at the edge, then check.
    task automatic cyc();
        @(posedge CLK);
        model_step(REQ, MODE);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int high;
        int guard;
        int e;
        int seg;
        logic [7:0] r;

        tbl[0] = '{8'b0010_1001, 1'b0, 8'b0010_0000, 4'd5,  1'b0};
        tbl[1] = '{8'b0000_1001, 1'b0, 8'b0000_0000, 4'hF,  1'b0};
        tbl[2] = '{8'b0000_1001, 1'b0, 8'b0000_0000, 4'hF,  1'b0};
        tbl[3] = '{8'b0000_1001, 1'b0, 8'b0000_1000, 4'd3,  1'b0};
        tbl[4] = '{8'b0000_0000, 1'b0, 8'b0000_0000, 4'hF,  1'b0};
        tbl[5] = '{8'b0000_0000, 1'b0, 8'b0000_0000, 4'hF,  1'b0};

        // Reset and idle
        RST_N = 1'b0;
        REQ   = 8'h00;
        MODE  = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_gnt", 32'(GNT),     32'h0);
        chk("rst_id",  32'(GNT_ID),  32'hF);
        chk("rst_vld", 32'(GNT_VLD), 32'h0);
        chk("rst_to",  32'(TIMEOUT), 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (5) cyc();

        // Fixed priority table
        for (int i = 0; i < 6; i++) begin
            REQ  = tbl[i].req;
            MODE = tbl[i].mode;
            cyc();
            chk("tbl_gnt", 32'(GNT),     32'(tbl[i].gnt));
            chk("tbl_id",  32'(GNT_ID),  32'(tbl[i].id));
            chk("tbl_to",  32'(TIMEOUT), 32'(tbl[i].to));
        end

        // Round-robin rotation from a fresh LAST
        do_reset();
        MODE = 1'b1;
        for (int i = 0; i < 9; i++) begin
            e = (i == 8) ? 7 : 7 - i;
            REQ = 8'hFF;
            cyc();
            chk("rr_order", 32'(GNT_ID), 32'(e));
            REQ = 8'hFF & ~(8'h01 << e);
            cyc();
            REQ = 8'hFF;
            cyc();
        end
        REQ = 8'h00;
        cyc();
        cyc();
        cyc();

        // Timeout after MAX_HOLD cycles, then re-grant
        MODE = 1'b0;
        REQ  = 8'b0000_0100;
        cyc();
        high  = 0;
        guard = 0;
        while (GNT == 8'b0000_0100 && guard < 40) begin
            high++;
            guard++;
            cyc();
        end
        chk("to_len",   32'(high),    32'(MAX_HOLD));
        chk("to_pulse", 32'(TIMEOUT), 32'h1);
        cyc();
        chk("to_clear", 32'(TIMEOUT), 32'h0);
        chk("to_gap",   32'(GNT),     32'h0);
        cyc();
        chk("to_regrant", 32'(GNT),   32'b0000_0100);
        REQ = 8'h00;
        cyc();
        cyc();

        // No preemption, MODE ignored outside IDLE
        REQ = 8'b0000_0010;
        cyc();
        chk("np_grant", 32'(GNT), 32'b0000_0010);
        REQ  = 8'b1000_0010;
        MODE = 1'b1;
        repeat (5) begin
            cyc();
            chk("np_hold", 32'(GNT), 32'b0000_0010);
        end
        REQ = 8'b1000_0000;
        cyc();
        chk("np_rel", 32'(GNT), 32'h0);
        MODE = 1'b0;
        cyc();
        cyc();
        chk("np_next", 32'(GNT), 32'b1000_0000);

        // Async reset mid-grant; LAST was 1 so a stale LAST would pick 0
        #3;
        RST_N = 1'b0;
        #1;
        chk("ar_gnt", 32'(GNT),     32'h0);
        chk("ar_id",  32'(GNT_ID),  32'hF);
        chk("ar_vld", 32'(GNT_VLD), 32'h0);
        model_reset();
        REQ  = 8'h81;
        MODE = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        cyc();
        chk("ar_rr", 32'(GNT_ID), 32'd7);
        REQ = 8'h00;
        cyc();
        cyc();

        // Randomized traffic
        for (int s = 0; s < 60; s++) begin
            seg = $urandom_range(1, 40);
            r   = 8'($urandom);
            if ($urandom_range(0, 1) == 1) r = r & 8'($urandom);
            if ($urandom_range(0, 7) == 0) r = 8'h00;
            MODE = 1'($urandom_range(0, 1));
            for (int c = 0; c < seg; c++) begin
                if ($urandom_range(0, 5) == 0) r = r ^ (8'h01 << $urandom_range(0, 7));
                if ($urandom_range(0, 9) == 0) MODE = ~MODE;
                REQ = r;
                cyc();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arb8_ctrl.md
Name: arb8_ctrl

Overview:
- Sequential 8-requester arbiter that shares one downstream resource between REQ[7:0].
- Uses the same priority convention and index coding as the team's 8-input priority encoder: REQ[7] is highest, the index is 4 bits, and 4'b1111 means "no grant".
- Supports fixed-priority or round-robin selection, holds the grant while the owner keeps requesting, and forces release after a bounded hold time.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one grant may stay asserted (legal range 2..31).
- CNT_W, 5, width of the hold counter; must satisfy 2^CNT_W >= MAX_HOLD.

Ports:
- CLK      input   1  rising-edge clock
- RST_N    input   1  asynchronous active-low reset
- REQ      input   8  request vector; one bit per requester
- MODE     input   1  0 = fixed priority (REQ[7] highest), 1 = round-robin
- GNT      output  8  one-hot grant; all zero when idle
- GNT_ID   output  4  index of granted requester 0..7; 4'b1111 when no grant
- GNT_VLD  output  1  high while any grant is held
- TIMEOUT  output  1  one-cycle pulse when a grant is forcibly revoked

Behaviour:
- All outputs are registered.
- Reset (RST_N low, async, valid at any time, including mid-grant):
  - state=IDLE, GNT=0, GNT_ID=4'b1111, GNT_VLD=0, TIMEOUT=0, hold_cnt=0, LAST=3'd0.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - REQ==0: stay in IDLE; outputs remain at their idle values.
  - REQ!=0: on the next edge, state<=GRANT, GNT<=onehot(W), GNT_ID<={1'b0,W}, GNT_VLD<=1, hold_cnt<=0.
  - Latency from REQ seen in IDLE to GNT high: 1 cycle.
  - MODE is sampled only in IDLE. A MODE change during GRANT or RELEASE has no effect until the next IDLE.
- Winner W selection:
  - Fixed mode: highest set bit of REQ.
  - Round-robin mode: first set bit in search order LAST-1, LAST-2, ..., LAST (mod 8). The most recently granted requester is searched last.
  - LAST resets to 0, so the initial round-robin order is 7..0, identical to fixed priority.
- GRANT, evaluated each edge, in this priority order:
  - REQ[GNT_ID]==0: go to RELEASE. This is a normal release; TIMEOUT stays 0.
  - Otherwise, if hold_cnt==MAX_HOLD-1: go to RELEASE and set TIMEOUT<=1.
  - Otherwise: hold_cnt<=hold_cnt+1.
  - GNT is therefore high for at most MAX_HOLD cycles.
  - Changes on other REQ bits are ignored during GRANT; there is no preemption, even by a higher-priority requester.
- On any transition GRANT->RELEASE:
  - GNT<=0, GNT_ID<=4'b1111, GNT_VLD<=0.
  - LAST<=GNT_ID[2:0]. LAST is updated in both modes.
- RELEASE:
  - Lasts exactly one cycle, then IDLE unconditionally.
  - TIMEOUT is high only during this cycle when set on entry; otherwise it is 0.
- Back-to-back throughput: the minimum gap between successive grants is 2 cycles (RELEASE + IDLE), guaranteeing a dead cycle on resource handover.
- Fixed mode after a timeout: the revoked requester may immediately win again if it is still the highest requester. Round-robin mode demotes it to lowest priority.
- Invariants, required at every cycle:
  - GNT has at most one bit set.
  - GNT_VLD == |GNT.
  - GNT_ID == 4'b1111 exactly when GNT == 0.

Test Plan:
- Reset and idle: hold RST_N=0, then release with REQ=0 for 5 cycles -> GNT=0, GNT_ID=4'b1111, GNT_VLD=0, TIMEOUT=0 throughout.
- Fixed priority: MODE=0, REQ=8'b0010_1001 -> one cycle later GNT=8'b0010_0000, GNT_ID=5. Then drop REQ[5] -> RELEASE, IDLE, then GNT=8'b0000_1000, GNT_ID=3.
- Round-robin: MODE=1, REQ=8'hFF held, each owner drops its REQ for one cycle after a 1-cycle grant -> grant order 7,6,5,4,3,2,1,0,7.
- Timeout: MAX_HOLD=16, REQ=8'b0000_0100 held -> GNT=8'b0000_0100 for exactly 16 cycles, TIMEOUT=1 for one cycle, and a new grant to requester 2 appears 2 cycles after GNT falls.
- No preemption / MODE latch: grant to requester 1 active, raise REQ[7] and toggle MODE -> GNT stays 8'b0000_0010 until REQ[1] drops.
- Async reset mid-grant: assert RST_N=0 mid-cycle while GNT=8'b1000_0000 -> GNT=0 and GNT_ID=4'b1111 immediately without a clock edge. After release with REQ=8'h81 in MODE=1 -> requester 7 wins, confirming LAST was cleared.
